laser_emitter_ctrl: RTL and testbench

- Transmit-side controller for the laser range finder: fires the laser with a programmable pulse width and opens a listen window sized to the range counter.
- Reports whether an echo arrived in the window, then enforces a cooling holdoff before the next shot.
- Sits upstream of the range receiver. laser_fire drives the laser driver; the receiver sees the emission on its emitted-light sensor input.
- Supports single-shot (start) and continuous (cont_en) operation, plus a safety abort.

---
 rtl/lrf_pkg.sv | 18 +
 rtl/lrf_down_timer.sv | 26 ++
 rtl/laser_emitter_ctrl.sv | 134 +++++++++++++
 tb/tb_laser_emitter_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lrf_pkg.sv
// Shared definitions for the laser range finder emitter and receiver.
// Window width default is shared so both sides agree on range.
package lrf_pkg;

  localparam int LRF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRE   = 2'd1,
    ST_LISTEN = 2'd2,
    ST_HOLD   = 2'd3
  } lrf_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lrf_down_timer.sv
// Loadable down-counter with zero flag.
// Times both the laser pulse and the cooling holdoff.
module lrf_down_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/laser_emitter_ctrl.sv
// Laser emitter controller: fire, listen for echo, cool down.
// Single-shot or continuous operation with a safety abort.
module laser_emitter_ctrl
  import lrf_pkg::*;
#(
  parameter int WIDTH   = LRF_WIDTH,
  parameter int PW      = 4,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont_en,
  input  logic             abort,
  input  logic [PW-1:0]    pulse_len,
  input  logic             rec_sensor,
  output logic             laser_fire,
  output logic             busy,
  output logic             echo_ok,
  output logic             shot_done,
  output logic [CNT_W-1:0] shot_cnt
);

  localparam int TW = max_int(PW, $clog2(HOLDOFF + 1));
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLDOFF - 1);
  localparam logic HOLD_ONE = (HOLDOFF == 1);

  lrf_state_t state;
  logic [WIDTH-1:0] win_cnt;
  logic [PW-1:0]    pl_m1;
  logic [TW-1:0]    tmr_val;
  logic [TW-1:0]    tmr_cnt;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             go;
  logic             to_hold;

  assign go    = (start | cont_en) & ~abort;
  assign pl_m1 = (pulse_len == '0) ? '0 : pulse_len - 1'b1;
  assign busy  = (state != ST_IDLE);

  // rec_sensor is blanked in FIRE; only abort leaves FIRE early
  assign to_hold =
    (state == ST_FIRE && abort) ||
    (state == ST_LISTEN &&
     (abort || rec_sensor || (&win_cnt)));

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tmr_load = go;
        tmr_val  = TW'(pl_m1);
      end
      ST_FIRE: begin
        tmr_load = to_hold;
        tmr_val  = HOLD_LD;
        tmr_dec  = 1'b1;
      end
      ST_LISTEN: begin
        tmr_load = to_hold;
        tmr_val  = HOLD_LD;
      end
      ST_HOLD: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  lrf_down_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      laser_fire <= 1'b0;
      echo_ok    <= 1'b0;
      shot_done  <= 1'b0;
      shot_cnt   <= '0;
      win_cnt    <= '0;
    end else begin
      shot_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            state      <= ST_FIRE;
            laser_fire <= 1'b1;
          end
        end
        ST_FIRE: begin
          if (abort) begin
            state      <= ST_HOLD;
            laser_fire <= 1'b0;
            echo_ok    <= 1'b0;
            shot_done  <= HOLD_ONE;
          end else if (tmr_zero) begin
            state      <= ST_LISTEN;
            laser_fire <= 1'b0;
            win_cnt    <= '0;
          end
        end
        ST_LISTEN: begin
          win_cnt <= win_cnt + 1'b1;
          if (to_hold) begin
            state     <= ST_HOLD;
            echo_ok   <= rec_sensor & ~abort;
            shot_done <= HOLD_ONE;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            state    <= ST_IDLE;
            shot_cnt <= shot_cnt + 1'b1;
          end else begin
            // registered pulse lands on the final HOLD cycle
            shot_done <= (tmr_cnt == TW'(1));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_emitter_ctrl.sv
// Scoreboard bench for laser_emitter_ctrl.
// Shots are scheduled per cycle; expectations come from shot arithmetic.
module tb_laser_emitter_ctrl;

  localparam int WIDTH   = 8;
  localparam int PW      = 4;
  localparam int HOLDOFF = 16;
  localparam int CNT_W   = 4;
  localparam int WIN     = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cont_en = 1'b0;
  logic abort = 1'b0;
  logic rec_sensor = 1'b0;
  logic [PW-1:0] pulse_len = '0;
  logic laser_fire;
  logic busy;
  logic echo_ok;
  logic shot_done;
  logic [CNT_W-1:0] shot_cnt;

  typedef struct {
    int pw;
    int len;
    bit echo;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int model_shots = 0;
  int done_seen = 0;
  bit cont_phase = 0;

  always #5 clk = ~clk;

  laser_emitter_ctrl #(
    .WIDTH(WIDTH), .PW(PW),
    .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont_en    (cont_en),
    .abort      (abort),
    .pulse_len  (pulse_len),
    .rec_sensor (rec_sensor),
    .laser_fire (laser_fire),
    .busy       (busy),
    .echo_ok    (echo_ok),
    .shot_done  (shot_done),
    .shot_cnt   (shot_cnt)
  );

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: measures each shot and pops the scoreboard on shot_done
  int  pw = 0, slen = 0, cyc = 0, last_rise = 0;
  bit  in_shot = 0, have_rise = 0, prev_fire = 0;

  always @(negedge clk) begin
    if (rst) begin
      pw = 0; slen = 0; in_shot = 0;
      have_rise = 0; prev_fire = 0;
    end else begin
      cyc++;
      if (laser_fire && !prev_fire) begin
        if (cont_phase && have_rise)
          check("cont_spacing", cyc - last_rise, 19);
        last_rise = cyc; have_rise = 1;
        pw = 0; slen = 0; in_shot = 1;
      end
      if (laser_fire) pw++;
      if (in_shot) slen++;
      if (shot_done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_shot_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pulse_width", pw, e.pw);
          check("shot_length", slen, e.len);
          check("echo_ok", int'(echo_ok), int'(e.echo));
          check("shot_cnt", int'(shot_cnt), e.cnt);
        end
        in_shot = 0;
      end
      prev_fire = laser_fire;
    end
  end

  task automatic push(input int pwv, input int len, input bit echo);
    exp_t x;
    x.pw = pwv; x.len = len; x.echo = echo;
    x.cnt = model_shots % (1 << CNT_W);
    sb.push_back(x);
    model_shots++;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 600) begin
      @(posedge clk); #1;
      start = 0; rec_sensor = 0; abort = 0;
      w++;
    end
    start = 0; rec_sensor = 0; abort = 0;
    check("return_idle", int'(busy), 0);
  endtask

  // mode 0: echo at listen cycle p, 1: timeout,
  // 2: abort in fire cycle p (1-based), 3: abort in listen cycle p
  task automatic shot(input int raw, input int mode, input int p);
    int L, last;
    L = (raw == 0) ? 1 : raw;
    case (mode)
      0: begin push(L, L + p + 1 + HOLDOFF, 1); last = L + 1 + p; end
      1: begin push(L, L + WIN + HOLDOFF, 0); last = L + WIN; end
      2: begin push(p, p + HOLDOFF, 0); last = p; end
      default: begin
        push(L, L + p + 1 + HOLDOFF, 0); last = L + 1 + p;
      end
    endcase
    pulse_len = PW'(raw);
    start = 1;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      start = 0;
      pulse_len = PW'($urandom);
      if (c <= L) begin
        rec_sensor = 1'($urandom);
        abort = (mode == 2 && c == p);
      end else begin
        rec_sensor = (mode == 0 && c - L - 1 == p);
        abort = (mode == 3 && c - L - 1 == p);
      end
    end
    @(posedge clk); #1;
    start = 1;
    rec_sensor = 1'($urandom);
    abort = 1'($urandom);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, w, viol, mode, raw, L, p;
    #1 rst = 1;
    #2;
    check("rst_laser_fire", int'(laser_fire), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_echo_ok", int'(echo_ok), 0);
    check("rst_shot_done", int'(shot_done), 0);
    check("rst_shot_cnt", int'(shot_cnt), 0);
    #14 rst = 0;
    @(posedge clk); #1;

    shot(3, 0, 5);
    shot(2, 1, 0);
    shot(0, 0, 255);
    shot(5, 2, 2);
    shot(0, 3, 10);

    @(posedge clk); #1;
    abort = 1; cont_en = 1; start = 1;
    viol = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy || laser_fire) viol++;
    end
    check("abort_holds_idle", viol, 0);
    abort = 0; cont_en = 0; start = 0;
    @(posedge clk); #1;

    pulse_len = 1; rec_sensor = 1;
    have_rise = 0; cont_phase = 1;
    base = done_seen;
    repeat (3) push(1, 1 + 1 + HOLDOFF, 1);
    cont_en = 1;
    w = 0;
    while (done_seen < base + 3 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    cont_en = 0; rec_sensor = 0; cont_phase = 0;
    check("cont_shots", done_seen - base, 3);
    wait_idle();

    repeat (14) begin
      mode = $urandom_range(0, 3);
      raw = $urandom_range(0, 15);
      L = (raw == 0) ? 1 : raw;
      case (mode)
        0: p = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 40);
        1: p = 0;
        2: p = $urandom_range(1, L);
        default: p = $urandom_range(0, 40);
      endcase
      shot(raw, mode, p);
      @(posedge clk); #1;
    end

    pulse_len = 8; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #3;
    check("fire_before_rst", int'(laser_fire), 1);
    rst = 1; #1;
    check("rst_mid_laser_fire", int'(laser_fire), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_shot_cnt", int'(shot_cnt), 0);
    check("rst_mid_echo_ok", int'(echo_ok), 0);
    sb.delete();
    model_shots = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    shot(4, 0, 3);
    shot(1, 1, 0);

    repeat (30) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
